two_com_serial_dec: RTL and testbench



---
 rtl/two_com_pkg.sv | 17 +
 rtl/two_com_serial_cell.sv | 15 +
 rtl/two_com_serial_dec.sv | 119 +++++++++++
 tb/tb_two_com_serial_dec.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/two_com_pkg.sv
// Shared types and helpers for the bit-serial two's-complement codec blocks.
package two_com_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 4;

  // The counter runs 0..width-1; keep at least one bit for width=2.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/two_com_serial_cell.sv
// Per-bit copy-until-first-1-then-invert element for serial two's-complement magnitude.
module two_com_serial_cell (
  input  logic b,
  input  logic sign,
  input  logic seen_one,
  output logic o,
  output logic seen_one_next
);

  always_comb begin
    o             = (sign && seen_one) ? ~b : b;
    seen_one_next = sign ? (seen_one | b) : seen_one;
  end

endmodule

// File: rtl/two_com_serial_dec.sv
// Bit-serial two's-complement to sign-magnitude decoder with valid/ready on both sides.
module two_com_serial_dec
  import two_com_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sign,
  output logic [WIDTH-1:0] m_mag,
  output logic             m_min
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_PAT = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] res;
  logic             sign;
  logic             seen_one;
  logic [WIDTH-1:0] mag_r;
  logic             sign_r;
  logic             min_r;
  logic             accept;
  logic             conv_en;
  logic             cnt_last;
  logic             cell_o;
  logic             cell_seen_nxt;
  logic [WIDTH-1:0] res_nxt;

  function automatic logic is_min(input logic sg, input logic [WIDTH-1:0] mag);
    return sg && (mag == MIN_PAT);
  endfunction

  two_com_serial_cell u_cell (
    .b             (shreg[0]),
    .sign          (sign),
    .seen_one      (seen_one),
    .o             (cell_o),
    .seen_one_next (cell_seen_nxt)
  );

  assign cnt_last = (cnt == LAST);
  assign res_nxt  = {cell_o, res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RECV;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    accept    = 1'b0;
    conv_en   = 1'b0;
    case (state)
      RECV: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid && cnt_last) state_nxt = CONV;
      end
      CONV: begin
        conv_en = 1'b1;
        if (cnt_last) state_nxt = HOLD;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = RECV;
      end
      default: state_nxt = RECV;
    endcase
  end

  // Receive shifts bits in at the MSB; convert drains them from the LSB into res.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shreg    <= '0;
      res      <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      mag_r    <= '0;
      sign_r   <= 1'b0;
      min_r    <= 1'b0;
    end else if (accept) begin
      shreg <= {s_bit, shreg[WIDTH-1:1]};
      cnt   <= cnt_last ? '0 : cnt + CW'(1);
      if (cnt_last) begin
        sign     <= s_bit;
        seen_one <= 1'b0;
      end
    end else if (conv_en) begin
      shreg    <= {1'b0, shreg[WIDTH-1:1]};
      res      <= res_nxt;
      seen_one <= cell_seen_nxt;
      cnt      <= cnt_last ? '0 : cnt + CW'(1);
      // Output registers only change when a full word completes, so they stay put through HOLD and after.
      if (cnt_last) begin
        mag_r  <= res_nxt;
        sign_r <= sign;
        min_r  <= is_min(sign, res_nxt);
      end
    end
  end

  assign m_sign = sign_r;
  assign m_mag  = mag_r;
  assign m_min  = min_r;

endmodule

// File: tb/tb_two_com_serial_dec.sv
// Scoreboard bench for two_com_serial_dec: directed and random words against an arithmetic model.
module tb_two_com_serial_dec;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_bit = 1'b0;
  logic         s_ready;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_sign;
  logic [W-1:0] m_mag;
  logic         m_min;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int rdy_mode = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;
  logic mv_prev = 1'b0;

  two_com_serial_dec #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_bit   (s_bit),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_sign  (m_sign),
    .m_mag   (m_mag),
    .m_min   (m_min)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {sign, min, mag} from the signed value of the word.
  function automatic logic [W+1:0] model(input int w);
    int   v;
    int   mag;
    logic sg;
    logic mn;
    sg  = ((w >> (W - 1)) & 1) != 0;
    v   = sg ? w - (1 << W) : w;
    mag = (v < 0) ? -v : v;
    mn  = (v == -(1 << (W - 1)));
    return {sg, mn, mag[W-1:0]};
  endfunction

  // Inputs change at posedge+1; s_ready sampled on the negedge before the accepting edge.
  task automatic send_bit(input logic b, input int gap);
    logic ok;
    int   t;
    repeat (gap) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_bit   = b;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept expected=accept (t=%0t)", $time);
    end
    last_acc = cyc;
    s_valid  = 1'b0;
  endtask

  task automatic send_word(input int w, input int gap, input bit push);
    if (push) exp_q.push_back(model(w));
    for (int i = 0; i < W; i++)
      send_bit(((w >> i) & 1) != 0, (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) m_ready = 1'($urandom_range(0, 1));
      else               m_ready = (rdy_mode == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mv_prev <= 1'b0;
    end else begin
      if (m_valid && !mv_prev) chk("latency", cyc - last_acc, W);
      if (m_valid) chk("s_ready_low_in_hold", s_ready, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=mag%0d expected=none", m_mag);
        end else begin
          mon_e = exp_q.pop_front();
          chk("m_sign", m_sign, mon_e[W+1]);
          chk("m_min", m_min, mon_e[W]);
          chk("m_mag", m_mag, mon_e[W-1:0]);
        end
      end
      mv_prev <= m_valid;
    end
  end

  initial begin
    logic [W+1:0] e;
    int t;
    repeat (3) @(posedge clk); #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sign", m_sign, 0);
    chk("rst_m_mag", m_mag, 0);
    chk("rst_m_min", m_min, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rdy_mode = 0;
    send_word(5, 0, 1);
    send_word(11, 0, 1);
    send_word(15, 0, 1);
    send_word(8, 0, 1);
    send_word(0, 0, 1);
    send_word(6, 1, 1);
    drain();

    // Backpressure with s_valid held high during HOLD.
    rdy_mode = 2;
    m_ready  = 1'b0;
    e = model(5);
    send_word(5, 0, 1);
    t = 0;
    while (!m_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_reached_hold", m_valid, 1);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_m_mag", m_mag, e[W-1:0]);
      chk("bp_m_sign", m_sign, e[W+1]);
      @(posedge clk); #1;
    end
    s_valid  = 1'b0;
    rdy_mode = 0;
    m_ready  = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_m_valid", m_valid, 0);
    chk("bp_release_s_ready", s_ready, 1);
    chk("bp_queue_popped", exp_q.size(), 0);

    // Asynchronous reset while converting, then a clean word.
    send_word(7, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_s_ready", s_ready, 1);
    chk("async_rst_m_valid", m_valid, 0);
    chk("async_rst_m_mag", m_mag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(13, 0, 1);
    drain();

    rdy_mode = 1;
    for (int n = 0; n < 40; n++) send_word(int'($urandom_range(0, (1 << W) - 1)), -1, 1);
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
